// File: rtl/prll_bs_drvr_fifo_endpoint.sv
// Driver-side endpoint for the parallel bus generator/arbiter.
// The TX FIFO buffers user packets and presents its head to the arbiter
// (pndng/D_pop), advancing on pop. The RX FIFO captures bus packets
// addressed to this driver (or broadcast) for the user. Packets the RX
// side cannot take are counted in a saturating drop counter.

// First-word-fall-through FIFO: the head is visible on rd_data whenever
// count is non-zero. Callers gate wr_en/rd_en with full/empty themselves.
module prll_bs_drvr_fifo #(
   parameter  int W     = 256,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   output logic [W-1:0]  rd_data,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         if (wr_en && !rd_en)      count <= count + 1'b1;
         else if (!wr_en && rd_en) count <= count - 1'b1;
      end
   end

   // Packet storage.
   // NOTE: the array has no reset; contents are don't-care until the count says they are valid.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];

endmodule

module prll_bs_drvr_fifo_endpoint #(
   parameter  int         bits      = 256,
   parameter  int         depth     = 8,
   parameter  logic [7:0] id        = 8'd0,
   parameter  logic [7:0] broadcast = 8'hFF,
   localparam int         CW        = $clog2(depth) + 1
) (
   input  logic            clk,
   input  logic            reset,
   // arbiter side
   output logic            pndng,
   input  logic            pop,
   output logic [bits-1:0] D_pop,
   input  logic            push,
   input  logic [bits-1:0] D_push,
   // user side
   input  logic            tx_valid,
   output logic            tx_ready,
   input  logic [bits-1:0] tx_data,
   output logic            rx_valid,
   input  logic            rx_ready,
   output logic [bits-1:0] rx_data,
   // status
   output logic [CW-1:0]   tx_count,
   output logic [CW-1:0]   rx_count,
   output logic [15:0]     rx_drop_cnt
);

   localparam logic [CW-1:0] FULL = CW'(depth);

   logic       tx_wr;
   logic       tx_rd;
   logic       rx_wr;
   logic       rx_rd;
   logic       rx_drop;
   logic       match;
   logic [7:0] dest;

   // TX: user writes when not full (no same-cycle pop bypass); arbiter pops only a valid head.
   assign tx_ready = (tx_count != FULL);
   assign pndng    = (tx_count != '0);
   assign tx_wr    = tx_valid && tx_ready;
   assign tx_rd    = pop && pndng;

   prll_bs_drvr_fifo #(.W(bits), .DEPTH(depth)) u_tx_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (tx_wr),
      .wr_data (tx_data),
      .rd_en   (tx_rd),
      .rd_data (D_pop),
      .count   (tx_count)
   );

   // RX address filter: accept own ID or broadcast; the full check uses the current count only.
   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      dest    = D_push[bits-1 -: 8];
      match   = (dest == id) || (dest == broadcast);
      rx_wr   = 1'b0;
      rx_drop = 1'b0;
      if (push) begin
         if (match && (rx_count != FULL)) rx_wr   = 1'b1;
         else                             rx_drop = 1'b1;
      end
   end

   assign rx_valid = (rx_count != '0);
   assign rx_rd    = rx_valid && rx_ready;

   prll_bs_drvr_fifo #(.W(bits), .DEPTH(depth)) u_rx_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (rx_wr),
      .wr_data (D_push),
      .rd_en   (rx_rd),
      .rd_data (rx_data),
      .count   (rx_count)
   );

   // Saturating count of bus packets that were filtered out or arrived while RX was full.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                   rx_drop_cnt <= '0;
      else if (rx_drop && rx_drop_cnt != 16'hFFFF) rx_drop_cnt <= rx_drop_cnt + 16'd1;
   end

endmodule

// File: tb/tb_prll_bs_drvr_fifo_endpoint.sv
// Bench for prll_bs_drvr_fifo_endpoint (id=3): directed stimulus, a queue
// model checked every cycle, and hand-computed literal expectations.
module tb_prll_bs_drvr_fifo_endpoint;

   localparam int BITS  = 256;
   localparam int DEPTH = 8;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            reset;
   logic            pndng, pop, push, tx_valid, tx_ready, rx_valid, rx_ready;
   logic [BITS-1:0] D_pop, D_push, tx_data, rx_data;
   logic [CW-1:0]   tx_count, rx_count;
   logic [15:0]     rx_drop_cnt;

   int total = 0;
   int bad   = 0;
   bit check_en = 1'b0;

   // reference model state
   logic [BITS-1:0] tx_q[$];
   logic [BITS-1:0] rx_q[$];
   int              m_drop;

   prll_bs_drvr_fifo_endpoint #(.bits(BITS), .depth(DEPTH), .id(8'd3), .broadcast(8'hFF)) dut (
      .clk         (clk),
      .reset       (reset),
      .pndng       (pndng),
      .pop         (pop),
      .D_pop       (D_pop),
      .push        (push),
      .D_push      (D_push),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_data     (tx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .rx_data     (rx_data),
      .tx_count    (tx_count),
      .rx_count    (rx_count),
      .rx_drop_cnt (rx_drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [BITS-1:0] mk(input logic [7:0] dest, input logic [15:0] v);
      return {dest, 232'd0, v};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Model: FIFO semantics from the rules, decided on pre-edge occupancy.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_q.delete();
         rx_q.delete();
         m_drop = 0;
      end else begin
         bit do_tx_wr, do_tx_rd, do_rx_wr, do_rx_rd, do_drop, hit;
         hit      = (D_push[BITS-1 -: 8] == 8'd3) || (D_push[BITS-1 -: 8] == 8'hFF);
         do_tx_wr = tx_valid && (tx_q.size() < DEPTH);
         do_tx_rd = pop && (tx_q.size() > 0);
         do_rx_wr = push && hit && (rx_q.size() < DEPTH);
         do_drop  = push && !do_rx_wr;
         do_rx_rd = rx_ready && (rx_q.size() > 0);
         if (do_tx_rd) void'(tx_q.pop_front());
         if (do_tx_wr) tx_q.push_back(tx_data);
         if (do_rx_rd) void'(rx_q.pop_front());
         if (do_rx_wr) rx_q.push_back(D_push);
         if (do_drop && m_drop < 65535) m_drop++;
      end
   end

   // Compare DUT against the model on every falling edge out of reset.
   always @(negedge clk) begin
      if (check_en && !reset) begin
         check("pndng",    256'(pndng),       256'(tx_q.size() != 0));
         check("tx_ready", 256'(tx_ready),    256'(tx_q.size() != DEPTH));
         check("tx_count", 256'(tx_count),    256'(tx_q.size()));
         check("rx_valid", 256'(rx_valid),    256'(rx_q.size() != 0));
         check("rx_count", 256'(rx_count),    256'(rx_q.size()));
         check("drop_cnt", 256'(rx_drop_cnt), 256'(m_drop));
         if (tx_q.size() != 0) check("D_pop",   D_pop,   tx_q[0]);
         if (rx_q.size() != 0) check("rx_data", rx_data, rx_q[0]);
      end
   end

   initial begin
      reset = 1'b1; pop = 0; push = 0; D_push = '0;
      tx_valid = 0; tx_data = '0; rx_ready = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check_en = 1'b1;

      // reset state
      check("rst pndng",    256'(pndng),       256'(0));
      check("rst rx_valid", 256'(rx_valid),    256'(0));
      check("rst tx_ready", 256'(tx_ready),    256'(1));
      check("rst tx_count", 256'(tx_count),    256'(0));
      check("rst rx_count", 256'(rx_count),    256'(0));
      check("rst drop",     256'(rx_drop_cnt), 256'(0));

      // three TX writes, pndng one cycle after the first
      tx_valid = 1; tx_data = mk(8'h00, 16'hA1); step();
      check("pndng after 1st wr", 256'(pndng), 256'(1));
      tx_data = mk(8'h00, 16'hA2); step();
      tx_data = mk(8'h00, 16'hA3); step();
      tx_valid = 0;
      pop = 1;
      for (int i = 0; i < 3; i++) begin
         check("pop order", D_pop, mk(8'h00, 16'(16'hA1 + i)));
         step();
      end
      pop = 0;
      check("pndng after 3 pops", 256'(pndng), 256'(0));

      // fill TX with tx_valid held; 9th word waits for a pop
      tx_valid = 1;
      for (int i = 0; i < 8; i++) begin
         tx_data = mk(8'h00, 16'(16'hB0 + i));
         step();
      end
      tx_data = mk(8'h00, 16'hB8);
      check("tx_ready at full", 256'(tx_ready), 256'(0));
      step();
      check("tx_count held full", 256'(tx_count), 256'(8));
      pop = 1; step(); pop = 0;
      check("tx_ready after pop", 256'(tx_ready), 256'(1));
      check("tx_count after pop", 256'(tx_count), 256'(7));
      step();
      tx_valid = 0;
      check("9th accepted", 256'(tx_count), 256'(8));
      pop = 1;
      for (int i = 1; i <= 8; i++) begin
         check("fill order", D_pop, mk(8'h00, 16'(16'hB0 + i)));
         step();
      end
      pop = 0;

      // simultaneous write and pop keeps the count
      tx_valid = 1; tx_data = mk(8'h00, 16'hD0); step();
      tx_data = mk(8'h00, 16'hD1); pop = 1; step();
      tx_valid = 0; pop = 0;
      check("wr+pop count", 256'(tx_count), 256'(1));
      check("wr+pop head",  D_pop, mk(8'h00, 16'hD1));
      pop = 1; step(); pop = 0;

      // RX filter: dest 3, FF, 5
      push = 1;
      D_push = mk(8'h03, 16'hC1); step();
      D_push = mk(8'hFF, 16'hC2); step();
      D_push = mk(8'h05, 16'hC3); step();
      push = 0;
      check("rx_count filter", 256'(rx_count),    256'(2));
      check("drop filter",     256'(rx_drop_cnt), 256'(1));
      check("rx head dest3",   rx_data, mk(8'h03, 16'hC1));

      // fill RX to 8, then push on full while reading
      push = 1;
      for (int i = 0; i < 6; i++) begin
         D_push = mk(8'h03, 16'(16'hE0 + i));
         step();
      end
      check("rx full count", 256'(rx_count), 256'(8));
      D_push = mk(8'h03, 16'hEE); rx_ready = 1; step();
      push = 0; rx_ready = 0;
      check("full push dropped", 256'(rx_drop_cnt), 256'(2));
      check("rx_count 7",        256'(rx_count),    256'(7));
      check("rx head destFF",    rx_data, mk(8'hFF, 16'hC2));

      // drain RX, bounded
      rx_ready = 1;
      for (int i = 0; i < 20; i++) begin
         if (!rx_valid) break;
         step();
      end
      rx_ready = 0;
      check("rx drained", 256'(rx_valid), 256'(0));

      // pop and rx_ready while both empty
      pop = 1; rx_ready = 1; step(); step();
      pop = 0; rx_ready = 0;
      check("empty tx_count", 256'(tx_count), 256'(0));
      check("empty rx_count", 256'(rx_count), 256'(0));
      check("empty pndng",    256'(pndng),    256'(0));
      check("empty rx_valid", 256'(rx_valid), 256'(0));
      tx_valid = 1; tx_data = mk(8'h00, 16'h77); step(); tx_valid = 0;
      check("after empty pop head", D_pop, mk(8'h00, 16'h77));
      pop = 1; step(); pop = 0;

      // mid-stream reset with 5 TX and 4 RX entries
      tx_valid = 1; push = 1;
      for (int i = 0; i < 5; i++) begin
         tx_data = mk(8'h00, 16'(16'hF0 + i));
         if (i == 4) push = 0;
         D_push = mk(8'h03, 16'(16'hF8 + i));
         step();
      end
      tx_valid = 0; push = 0;
      check("pre-reset tx_count", 256'(tx_count), 256'(5));
      check("pre-reset rx_count", 256'(rx_count), 256'(4));
      #2 reset = 1'b1;
      #1;
      check("async pndng",    256'(pndng),    256'(0));
      check("async rx_valid", 256'(rx_valid), 256'(0));
      check("async tx_count", 256'(tx_count), 256'(0));
      check("async rx_count", 256'(rx_count), 256'(0));
      step(); step();
      reset = 1'b0;
      check("post-reset tx_ready", 256'(tx_ready),    256'(1));
      check("post-reset drop",     256'(rx_drop_cnt), 256'(0));
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
